// File: rtl/psg_driver_pkg.sv
// psg_driver_pkg: shared encodings for the psg_driver slice.
// Holds the config-select codes, the sweep FSM state type and a
// clog2 helper used to size the channel index.
package psg_driver_pkg;

    localparam logic [1:0] CFG_PHASE_INC = 2'd0;
    localparam logic [1:0] CFG_VOL       = 2'd1;
    localparam logic [1:0] CFG_PHASE_RST = 2'd2;
    localparam logic [1:0] CFG_SWEEP     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_VOL   = 2'd2,
        ST_NEXT  = 2'd3
    } state_t;

    // Index width for n entries, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/psg_driver_regs.sv
// psg_driver_regs: per-channel state for the psg driver.
// Phase accumulators, phase increments, volume targets and the
// zero/volume pending flags, with a host write port, an update port
// driven by the sweep FSM and a single combinational read port.
// Optional build macro: PSG_DRIVER_SWEEP_EN adds signed per-channel
// sweep deltas that bend the phase increment after every phase word.
module psg_driver_regs
    import psg_driver_pkg::*;
#(
    parameter int NR_CHANNELS  = 3,
    parameter int OUTPUT_WIDTH = 24,
    parameter int CHW          = clog2_min1(NR_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr,
    input  logic [1:0]              cfg_sel,
    input  logic [CHW-1:0]          cfg_ch,
    input  logic [OUTPUT_WIDTH-1:0] cfg_d,
    input  logic                    phase_upd,
    input  logic                    vol_clr,
    input  logic [CHW-1:0]          upd_ch,
    input  logic [CHW-1:0]          rd_ch,
    output logic [OUTPUT_WIDTH-1:0] rd_acc,
    output logic [OUTPUT_WIDTH-1:0] rd_vol_target,
    output logic                    rd_zero_pending,
    output logic                    rd_vol_pending
);

    logic [OUTPUT_WIDTH-1:0] acc        [NR_CHANNELS];
    logic [OUTPUT_WIDTH-1:0] inc        [NR_CHANNELS];
    logic [OUTPUT_WIDTH-1:0] vol_target [NR_CHANNELS];
    logic [NR_CHANNELS-1:0]  zero_pending;
    logic [NR_CHANNELS-1:0]  vol_pending;

    logic wr_inc;
    logic wr_vol;
    logic wr_rst;

    assign wr_inc = cfg_wr && (cfg_sel == CFG_PHASE_INC);
    assign wr_vol = cfg_wr && (cfg_sel == CFG_VOL);
    assign wr_rst = cfg_wr && (cfg_sel == CFG_PHASE_RST);

    assign rd_acc          = acc[rd_ch];
    assign rd_vol_target   = vol_target[rd_ch];
    assign rd_zero_pending = zero_pending[rd_ch];
    assign rd_vol_pending  = vol_pending[rd_ch];

`ifdef PSG_DRIVER_SWEEP_EN
    logic signed [OUTPUT_WIDTH-1:0] sweep_delta [NR_CHANNELS];
    logic wr_sweep;

    assign wr_sweep = cfg_wr && (cfg_sel == CFG_SWEEP);

    // Increment plus signed delta, clamped to [0, 2^W-1].
    function automatic logic [OUTPUT_WIDTH-1:0] sweep_add(
        input logic [OUTPUT_WIDTH-1:0]        base,
        input logic signed [OUTPUT_WIDTH-1:0] delta
    );
        logic [OUTPUT_WIDTH+1:0] sum;
        sum = {2'b00, base} + {{2{delta[OUTPUT_WIDTH-1]}}, delta};
        if (sum[OUTPUT_WIDTH+1]) begin
            return '0;
        end else if (sum[OUTPUT_WIDTH]) begin
            return '1;
        end else begin
            return sum[OUTPUT_WIDTH-1:0];
        end
    endfunction

    // Host-written sweep deltas.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                sweep_delta[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                if (wr_sweep && cfg_ch == CHW'(i)) begin
                    sweep_delta[i] <= cfg_d;
                end
            end
        end
    end
`endif

    // Phase increments; a host write wins over the sweep adjustment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                inc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
`ifdef PSG_DRIVER_SWEEP_EN
                if (phase_upd && upd_ch == CHW'(i)) begin
                    inc[i] <= sweep_add(inc[i], sweep_delta[i]);
                end
`endif
                if (wr_inc && cfg_ch == CHW'(i)) begin
                    inc[i] <= cfg_d;
                end
            end
        end
    end

    // Accumulators advance after each phase word; a phase reset wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                acc[i] <= '0;
            end
            zero_pending <= '1;
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                if (phase_upd && upd_ch == CHW'(i)) begin
                    acc[i]          <= acc[i] + inc[i];
                    zero_pending[i] <= 1'b0;
                end
                if (wr_rst && cfg_ch == CHW'(i)) begin
                    acc[i]          <= '0;
                    zero_pending[i] <= 1'b1;
                end
            end
        end
    end

    // Volume targets; a fresh write re-arms pending over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                vol_target[i] <= '0;
            end
            vol_pending <= '0;
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                if (vol_clr && upd_ch == CHW'(i)) begin
                    vol_pending[i] <= 1'b0;
                end
                if (wr_vol && cfg_ch == CHW'(i)) begin
                    vol_target[i]  <= cfg_d;
                    vol_pending[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/psg_driver.sv
// psg_driver: per-sample control source for the psg sound generator.
// Each sample_tick sweeps all channels, sending one phase word per
// channel and a volume word only for channels whose target changed.
// Optional build macro: PSG_DRIVER_SWEEP_EN (per-channel pitch sweep,
// implemented inside psg_driver_regs).
module psg_driver
    import psg_driver_pkg::*;
#(
    parameter int NR_CHANNELS  = 3,
    parameter int OUTPUT_WIDTH = 24,
    parameter int CHW          = clog2_min1(NR_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_tick,
    input  logic                    cfg_wr,
    input  logic [1:0]              cfg_sel,
    input  logic [CHW-1:0]          cfg_ch,
    input  logic [OUTPUT_WIDTH-1:0] cfg_d,
    output logic [OUTPUT_WIDTH-1:0] m_phase_d,
    output logic [CHW-1:0]          m_phase_ch,
    output logic                    m_phase_dv,
    input  logic                    m_phase_dr,
    output logic                    m_sine_zero,
    output logic [OUTPUT_WIDTH-1:0] m_vol_d,
    output logic [CHW-1:0]          m_vol_ch,
    output logic                    m_vol_dv,
    input  logic                    m_vol_dr,
    output logic                    busy,
    output logic                    overrun
);

    state_t state;
    state_t next_state;

    logic [CHW-1:0]          ch_idx;
    logic [CHW-1:0]          rd_ch;
    logic [OUTPUT_WIDTH-1:0] rd_acc;
    logic [OUTPUT_WIDTH-1:0] rd_vol_target;
    logic                    rd_zero_pending;
    logic                    rd_vol_pending;
    logic                    phase_done;
    logic                    vol_done;
    logic                    vol_clr;
    logic                    vol_wr_hit;
    logic                    vol_rewritten;
    logic                    last_ch;

    assign phase_done = m_phase_dv && m_phase_dr;
    assign vol_done   = m_vol_dv && m_vol_dr;
    assign last_ch    = (ch_idx == CHW'(NR_CHANNELS - 1));
    assign vol_wr_hit = cfg_wr && (cfg_sel == CFG_VOL) && (cfg_ch == ch_idx);
    assign vol_clr    = vol_done && !vol_rewritten;

    // Read address: channel about to be loaded, or the one in flight.
    always_comb begin
        rd_ch = ch_idx;
        if (state == ST_IDLE) begin
            rd_ch = '0;
        end else if (state == ST_NEXT) begin
            rd_ch = ch_idx + CHW'(1);
        end
    end

    psg_driver_regs #(
        .NR_CHANNELS  (NR_CHANNELS),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .CHW          (CHW)
    ) u_regs (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wr          (cfg_wr),
        .cfg_sel         (cfg_sel),
        .cfg_ch          (cfg_ch),
        .cfg_d           (cfg_d),
        .phase_upd       (phase_done),
        .vol_clr         (vol_clr),
        .upd_ch          (ch_idx),
        .rd_ch           (rd_ch),
        .rd_acc          (rd_acc),
        .rd_vol_target   (rd_vol_target),
        .rd_zero_pending (rd_zero_pending),
        .rd_vol_pending  (rd_vol_pending)
    );

    // Sweep FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sweep FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (sample_tick) next_state = ST_PHASE;
            ST_PHASE: if (phase_done)  next_state = rd_vol_pending ? ST_VOL : ST_NEXT;
            ST_VOL:   if (vol_done)    next_state = ST_NEXT;
            ST_NEXT:  next_state = last_ch ? ST_IDLE : ST_PHASE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Valid and busy flags come straight from the state register.
    always_comb begin
        m_phase_dv = (state == ST_PHASE);
        m_vol_dv   = (state == ST_VOL);
        busy       = (state != ST_IDLE);
    end

    // Output word registers, loaded only when a new word is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_idx      <= '0;
            m_phase_d   <= '0;
            m_phase_ch  <= '0;
            m_sine_zero <= 1'b0;
            m_vol_d     <= '0;
            m_vol_ch    <= '0;
        end else begin
            if (state == ST_IDLE && sample_tick) begin
                ch_idx      <= '0;
                m_phase_d   <= rd_acc;
                m_phase_ch  <= '0;
                m_sine_zero <= rd_zero_pending;
            end else if (state == ST_NEXT && !last_ch) begin
                ch_idx      <= rd_ch;
                m_phase_d   <= rd_acc;
                m_phase_ch  <= rd_ch;
                m_sine_zero <= rd_zero_pending;
            end
            if (state == ST_PHASE && phase_done && rd_vol_pending) begin
                m_vol_d  <= rd_vol_target;
                m_vol_ch <= ch_idx;
            end
        end
    end

    // Remember a volume rewrite that lands after the word was latched,
    // so its pending flag survives into the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_rewritten <= 1'b0;
        end else if (state == ST_PHASE && phase_done) begin
            vol_rewritten <= vol_wr_hit;
        end else if (state == ST_VOL && vol_wr_hit) begin
            vol_rewritten <= 1'b1;
        end
    end

    // Sticky flag for ticks that arrive mid-sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_tick && state != ST_IDLE) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: doc/psg_driver.md
Name: psg_driver

Overview:
- Per-sample control source for the psg sound generator: drives its phase input (s_phase_swg_*, s_sine_zero) and volume input (s_vol_swg_*).
- Holds per-channel phase accumulators, phase increments and volume targets.
- On each sample tick, walks all channels round-robin. Issues one phase word per channel, plus a volume word only when that channel's volume target has changed.
- A host writes configuration through a simple register-write port.

Parameters:
- NR_CHANNELS, 3, number of voices; must match psg.
- OUTPUT_WIDTH, 24, phase/volume word width; must match psg.
- CHW, clog2(NR_CHANNELS) (min 1), channel index width; derived.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle strobe starting a channel sweep
- cfg_wr  in  1  config write strobe
- cfg_sel  in  2  0=phase_inc, 1=vol_target, 2=phase_reset, 3=reserved (ignored)
- cfg_ch  in  CHW  target channel
- cfg_d  in  OUTPUT_WIDTH  write data
- m_phase_d  out  OUTPUT_WIDTH  phase word to psg s_phase_swg_d
- m_phase_ch  out  CHW  channel for phase word
- m_phase_dv  out  1  phase valid
- m_phase_dr  in  1  from psg s_phase_swg_dr
- m_sine_zero  out  1  to psg s_sine_zero; qualified by m_phase_dv
- m_vol_d  out  OUTPUT_WIDTH  volume target to psg s_vol_swg_d
- m_vol_ch  out  CHW  channel for volume word
- m_vol_dv  out  1  volume valid
- m_vol_dr  in  1  from psg s_vol_swg_dr
- busy  out  1  sweep in progress
- overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, rst_n low): all outputs 0; accumulators, increments and volume targets 0; vol_pending all 0; zero_pending all 1; FSM IDLE.
- Handshake (both masters):
  - dv, d, ch, zero are registered and held stable while dv=1.
  - A transfer completes on the posedge where dv=1 and dr=1.
  - dv drops the cycle after completion unless the next word is issued back-to-back.
  - dv never depends combinationally on dr.
- FSM states: IDLE, PHASE, VOL, NEXT.
  - IDLE: on sample_tick, ch_idx=0, load ch0 phase word, m_phase_dv=1 at tick+1, busy=1, go PHASE.
  - PHASE: on completion, accumulator[ch] += phase_inc[ch] (modulo 2^OUTPUT_WIDTH, wrap silent) and zero_pending[ch] cleared. Then go VOL if vol_pending[ch], else NEXT.
  - VOL: m_vol_dv=1 with vol_target[ch]. On completion, clear vol_pending[ch] and go NEXT.
  - NEXT: if ch_idx==NR_CHANNELS-1, go IDLE and busy=0. Else ch_idx++, load next phase word, go PHASE.
- Phase word sent = accumulator value before increment, so channel 0 starts at phase 0.
- m_sine_zero = zero_pending[ch] at load time.
- Config writes:
  - phase_inc: takes effect on that channel's next accumulation.
  - vol_target: sets vol_pending.
  - phase_reset: accumulator=0, zero_pending=1.
- Config write to the channel currently in PHASE/VOL (data held in output regs): output word unchanged. A new vol_target written during that channel's VOL keeps vol_pending=1 for the next sweep. A phase_reset in the completion cycle wins over the increment.
- sample_tick while busy: dropped, overrun<=1 (sticky until reset).
- Minimum tick period with no stalls: 2*NR_CHANNELS+1 cycles.

Optional Feature:
- Macro PSG_DRIVER_SWEEP_EN.
- When defined:
  - adds cfg_sel=3 writing a signed per-channel sweep_delta (reset 0).
  - At each phase completion, phase_inc[ch] += sweep_delta[ch], saturating at 0 and 2^OUTPUT_WIDTH-1.
- When undefined: cfg_sel=3 ignored, no sweep registers synthesized.

Decomposition:
- Package psg_driver_pkg holds:
  - cfg_sel encodings (CFG_PHASE_INC, CFG_VOL, CFG_PHASE_RST, CFG_SWEEP)
  - FSM state encoding
  - clog2 helper
- One sub-module, psg_driver_regs: per-channel register file (increments, targets, pending flags, accumulators) with a write port and an update port.

Test Plan:
- Reset, NR_CHANNELS=3, inc ch0=0x000100, dr tied 1, two ticks 10 cycles apart -> sweep 1: ch0..2 phase 0 with m_sine_zero=1. Sweep 2: ch0 phase 0x000100, m_sine_zero=0. No m_vol_dv.
- Write vol_target ch1=0x400000, tick -> order ph0, ph1, vol1 (0x400000), ph2. Next tick has no vol word.
- m_phase_dr held low 5 cycles during ch1 -> m_phase_d/ch stable for all 5 cycles; single transfer; busy stays 1.
- inc ch0=0x800000, three ticks -> phases 0, 0x800000, 0x000000 (wrap).
- Tick on the cycle after a tick -> overrun=1, sweep unaffected. Assert rst_n low mid-VOL -> all dv 0 immediately, overrun 0.
- With PSG_DRIVER_SWEEP_EN: inc=0x10, delta=-0x8 -> increments 0x10, 0x8, 0, 0 (floor).
